serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 145 ++++++++++++++
 tb/tb_serial_subtractor.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), one full-subtractor cell reused LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic             bq_q, bq_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    // Full-subtractor cell built from two half-subtractor stages plus an OR.
    logic x, y, bin;
    logic hs1_d, hs1_b, hs2_b;
    logic bit_d, bit_bout;

    assign x        = op_a_q[0];
    assign y        = op_b_q[0];
    assign bin      = bq_q;
    assign hs1_d    = x ^ y;
    assign hs1_b    = ~x & y;
    assign bit_d    = hs1_d ^ bin;
    assign hs2_b    = ~hs1_d & bin;
    assign bit_bout = hs1_b | hs2_b;

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        part_d   = part_q;
        bq_d     = bq_q;
        count_d  = count_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    op_a_d  = a;
                    op_b_d  = b;
                    part_d  = '0;
                    bq_d    = 1'b0;
                    count_d = '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                part_d  = {bit_d, part_q[WIDTH-1:1]};
                op_a_d  = {1'b0, op_a_q[WIDTH-1:1]};
                op_b_d  = {1'b0, op_b_q[WIDTH-1:1]};
                bq_d    = bit_bout;
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    diff_d   = {bit_d, part_q[WIDTH-1:1]};
                    borrow_d = bit_bout;
`ifdef SERIAL_SUB_OVF_EN
                    // bit_d is the result MSB on the final bit.
                    ovf_d    = (a_msb_q != b_msb_q) & (bit_d != a_msb_q);
`endif
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_a_q   <= '0;
            op_b_q   <= '0;
            part_q   <= '0;
            bq_q     <= 1'b0;
            count_q  <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            part_q   <= part_d;
            bq_q     <= bq_d;
            count_q  <= count_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = (state_q == StRun);
    assign done   = (state_q == StDone);
    assign diff   = diff_q;
    assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8), hand-computed vectors.
module tb_serial_subtractor;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int checks;
    int errors;

    serial_subtractor #(
        .WIDTH(WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .borrow(borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start one operation, then count edges until done; expects done after exactly WIDTH edges.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] exp_diff, input logic exp_borrow,
                          input logic exp_ovf);
        int lat;
        int busy_cnt;
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_cnt++;
        end
        check({tag, "_latency"}, lat, WIDTH);
        check({tag, "_busy_cycles"}, busy_cnt, WIDTH);
        check({tag, "_busy_in_done"}, {31'd0, busy}, 0);
        check({tag, "_diff"}, {24'd0, diff}, {24'd0, exp_diff});
        check({tag, "_borrow"}, {31'd0, borrow}, {31'd0, exp_borrow});
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
`else
        if (exp_ovf === 1'bx) $display("note: unknown ovf expectation for %s", tag);
`endif
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, {31'd0, done}, 0);
        check({tag, "_diff_hold"}, {24'd0, diff}, {24'd0, exp_diff});
    endtask

    logic [7:0] b2b_a    [3];
    logic [7:0] b2b_b    [3];
    logic [7:0] b2b_diff [3];
    logic       b2b_brw  [3];
    logic       b2b_ovf  [3];

    initial begin
        int n_done;
        int op;
        logic exp_done;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;

        #12;
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_diff", {24'd0, diff}, 0);
        check("reset_borrow", {31'd0, borrow}, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset_ovf", {31'd0, ovf}, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_op("op_05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op("op_03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op("op_00_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run_op("op_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op("op_7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        run_op("op_10_01", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);
        run_op("op_00_01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        run_op("op_ff_ff", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);

        // start re-pulsed 3 cycles into RUN must be ignored.
        @(negedge clk);
        a = 8'h05;
        b = 8'h03;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a = 8'h01;
        b = 8'h40;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_done = 0;
        for (int i = 5; i <= 24; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                check("ign_latency", i, WIDTH);
                check("ign_diff", {24'd0, diff}, 32'h02);
                check("ign_borrow", {31'd0, borrow}, 0);
            end
        end
        check("ign_done_count", n_done, 1);

        // start held high: accept at edges 0, 9, 18; done after edges 8, 17, 26.
        b2b_a[0] = 8'h20; b2b_b[0] = 8'h10; b2b_diff[0] = 8'h10; b2b_brw[0] = 1'b0;
        b2b_ovf[0] = 1'b0;
        b2b_a[1] = 8'h01; b2b_b[1] = 8'h02; b2b_diff[1] = 8'hFF; b2b_brw[1] = 1'b1;
        b2b_ovf[1] = 1'b0;
        b2b_a[2] = 8'hAA; b2b_b[2] = 8'h55; b2b_diff[2] = 8'h55; b2b_brw[2] = 1'b0;
        b2b_ovf[2] = 1'b1;
        @(negedge clk);
        a = b2b_a[0];
        b = b2b_b[0];
        start = 1'b1;
        @(posedge clk);
        #1;
        op = 0;
        n_done = 0;
        a = b2b_a[1];
        b = b2b_b[1];
        check("b2b_busy_0", {31'd0, busy}, 1);
        for (int i = 1; i <= 26; i++) begin
            @(posedge clk);
            #1;
            exp_done = (i == 8) || (i == 17) || (i == 26);
            check("b2b_done", {31'd0, done}, {31'd0, exp_done});
            check("b2b_busy", {31'd0, busy}, {31'd0, ~exp_done});
            if (done) begin
                n_done++;
                if (op < 3) begin
                    check("b2b_diff", {24'd0, diff}, {24'd0, b2b_diff[op]});
                    check("b2b_borrow", {31'd0, borrow}, {31'd0, b2b_brw[op]});
`ifdef SERIAL_SUB_OVF_EN
                    check("b2b_ovf", {31'd0, ovf}, {31'd0, b2b_ovf[op]});
`endif
                end
                op++;
            end
            if (i == 9) begin
                a = b2b_a[2];
                b = b2b_b[2];
            end
            if (i == 26) start = 1'b0;
        end
        check("b2b_done_count", n_done, 3);
        @(posedge clk);
        #1;
        check("b2b_idle_after", {30'd0, busy, done}, 0);

        // Reset mid-RUN aborts the operation.
        @(negedge clk);
        a = 8'h05;
        b = 8'h03;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_diff", {24'd0, diff}, 0);
        check("rst_borrow", {31'd0, borrow}, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", {31'd0, ovf}, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) n_done++;
        end
        check("rst_no_activity", n_done, 0);
        run_op("post_rst", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
